wbuffer: RTL and testbench

Store write buffer sitting between the memory stage and the data memory port. It accepts speculative stores (`wbuffer_wreq_t`) in program order and marks them committed in order (`wbuffer_creq_t`). Only committed stores drain to memory, oldest first. Loads probe it (`wbuffer_rreq_t`) and get byte-granular forwarded data (`wbuffer_rresp_t`). A flush discards every store that has not yet committed.

---
 rtl/wbuffer_if.sv | 60 ++++++
 rtl/wbuffer.sv | 136 +++++++++++++
 tb/tb_wbuffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wbuffer_if.sv
// Store write buffer types and bus interface.
// The core/memory side uses the master modport; the buffer uses slave.
// Entry strobe/data are aligned to the entry address: strobe bit 0 and
// data byte 0 belong to the byte at addr.

package wbuffer_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  msize;
        logic [7:0]  strobe;
        logic [63:0] data;
    } wbuffer_entry_t;

    typedef struct packed {
        logic           valid;
        wbuffer_entry_t entry;
    } wbuffer_wreq_t;

    typedef struct packed {
        logic valid;
    } wbuffer_creq_t;

    typedef struct packed {
        logic [31:0] addr;
    } wbuffer_rreq_t;

    typedef struct packed {
        logic [7:0]  valid;
        logic [63:0] data;
    } wbuffer_rresp_t;

endpackage

interface wbuffer_if;
    import wbuffer_pkg::*;

    wbuffer_wreq_t  wreq;
    logic           wreq_ready;
    wbuffer_creq_t  creq;
    logic           flush;
    wbuffer_rreq_t  rreq;
    wbuffer_rresp_t rresp;
    logic           rreq_conflict;
    logic           mem_valid;
    wbuffer_entry_t mem_req;
    logic           mem_ready;
    logic           empty;

    modport master (
        output wreq, creq, flush, rreq, mem_ready,
        input  wreq_ready, rresp, rreq_conflict, mem_valid, mem_req, empty
    );

    modport slave (
        input  wreq, creq, flush, rreq, mem_ready,
        output wreq_ready, rresp, rreq_conflict, mem_valid, mem_req, empty
    );

endinterface

// File: rtl/wbuffer.sv
// wbuffer: in-order store write buffer with commit, flush and load probe.
// Optional feature macro: WBUFFER_FORWARD_EN (byte forwarding to loads;
// when undefined, loads see rreq_conflict instead and rresp is zero).

module wbuffer
    import wbuffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input logic       clk,
    input logic       resetn,
    wbuffer_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] head, cptr, tail;
    logic [PW-1:0] head_n, cptr_n, tail_n;
    logic [PW-1:0] occ;
    logic          full;
    logic          do_push, do_commit, do_pop;

    wbuffer_entry_t entries [DEPTH];

    // Per-age view of the buffer: index k = 0 is the oldest live entry.
    logic       age_live   [DEPTH];
    logic       age_match  [DEPTH];
    logic [7:0] age_strobe [DEPTH];
    logic [63:0] age_data  [DEPTH];

    wbuffer_rresp_t rresp_c;
    logic           conflict_c;
    logic           probe_unused;

    assign occ  = tail - head;
    assign full = (occ == PW'(DEPTH));

    assign do_pop    = (head != cptr) && bus.mem_ready;
    assign do_commit = bus.creq.valid && (cptr != tail);
    assign do_push   = bus.wreq.valid && !full && !bus.flush;

    assign bus.wreq_ready = !full;
    assign bus.mem_valid  = (head != cptr);
    assign bus.mem_req    = entries[head[AW-1:0]];
    assign bus.empty      = (head == tail);
    assign bus.rresp         = rresp_c;
    assign bus.rreq_conflict = conflict_c;

    // Offset bits of the probe address are irrelevant to line matching.
    assign probe_unused = ^bus.rreq.addr[2:0];

    // Pointer next-state: pop, then commit, then flush (tail to new cptr), then push.
    always_comb begin
        head_n = head;
        cptr_n = cptr;
        tail_n = tail;
        if (do_pop) begin
            head_n = head + PW'(1);
        end
        if (do_commit) begin
            cptr_n = cptr + PW'(1);
        end
        if (bus.flush) begin
            tail_n = cptr_n;
        end else if (do_push) begin
            tail_n = tail + PW'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head <= '0;
            cptr <= '0;
            tail <= '0;
        end else begin
            head <= head_n;
            cptr <= cptr_n;
            tail <= tail_n;
        end
    end

    // Entry storage; liveness comes from the pointers, so payload needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[tail[AW-1:0]] <= bus.wreq.entry;
        end
    end

    // Line match and line-aligned strobe/data of each entry, ordered oldest first.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            age_live[k]   = 1'b0;
            age_match[k]  = 1'b0;
            age_strobe[k] = '0;
            age_data[k]   = '0;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            wbuffer_entry_t e;
            e             = entries[AW'(head[AW-1:0] + AW'(k))];
            age_live[k]   = (PW'(k) < occ);
            age_match[k]  = age_live[k] && (e.addr[31:3] == bus.rreq.addr[31:3]);
            age_strobe[k] = e.strobe << e.addr[2:0];
            age_data[k]   = e.data << {e.addr[2:0], 3'b000};
        end
    end

`ifdef WBUFFER_FORWARD_EN
    // Byte merge: walking oldest to youngest lets the youngest writer of each byte win.
    always_comb begin
        rresp_c    = '0;
        conflict_c = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (age_match[k] && age_strobe[k][b]) begin
                    rresp_c.valid[b]       = 1'b1;
                    rresp_c.data[8*b +: 8] = age_data[k][8*b +: 8];
                end
            end
        end
    end
`else
    // No forwarding: flag any live store touching the probed line.
    always_comb begin
        rresp_c    = '0;
        conflict_c = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (age_match[k] && (|age_strobe[k])) begin
                conflict_c = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wbuffer.sv
// Directed self-checking bench for wbuffer (DEPTH = 8).
// Expectations follow WBUFFER_FORWARD_EN when it is defined for the build.

module tb_wbuffer;
    import wbuffer_pkg::*;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    wbuffer_if bus ();

    wbuffer #(.DEPTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d);
        bus.wreq.valid        = 1'b1;
        bus.wreq.entry.addr   = a;
        bus.wreq.entry.msize  = 2'd3;
        bus.wreq.entry.strobe = s;
        bus.wreq.entry.data   = d;
        tick();
        bus.wreq.valid = 1'b0;
    endtask

    task automatic commit();
        bus.creq.valid = 1'b1;
        tick();
        bus.creq.valid = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    // Probe a line and compare against the expected forward result; without
    // forwarding, rresp must be zero and conflict must equal (fwd_valid != 0).
    task automatic probe(input string tag, input logic [31:0] a,
                         input logic [7:0] fwd_valid, input logic [63:0] fwd_data);
        bus.rreq.addr = a;
        #1;
`ifdef WBUFFER_FORWARD_EN
        check({tag, "_valid"}, 64'(bus.rresp.valid), 64'(fwd_valid));
        check({tag, "_data"}, bus.rresp.data, fwd_data);
        check({tag, "_conf"}, 64'(bus.rreq_conflict), 64'd0);
`else
        check({tag, "_valid"}, 64'(bus.rresp.valid), 64'd0);
        check({tag, "_data"}, bus.rresp.data, 64'd0);
        check({tag, "_conf"}, 64'(bus.rreq_conflict), 64'(fwd_valid != 8'h00));
`endif
        bus.rreq.addr = 32'hFFFF_0000;
    endtask

    initial begin
        logic [31:0] drained [4];
        int          drains;

        n_checks      = 0;
        n_fail        = 0;
        resetn        = 1'b0;
        bus.wreq      = '0;
        bus.creq      = '0;
        bus.flush     = 1'b0;
        bus.rreq.addr = 32'hFFFF_0000;
        bus.mem_ready = 1'b0;

        // Reset state
        #3;
        check("rst_wreq_ready", 64'(bus.wreq_ready), 64'd1);
        check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_rresp", 64'(bus.rresp.valid), 64'd0);
        check("rst_conflict", 64'(bus.rreq_conflict), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Single store: push, commit, drain
        push(32'h1000, 8'h0F, 64'h1122_3344);
        check("p1_empty", 64'(bus.empty), 64'd0);
        check("p1_mem_valid", 64'(bus.mem_valid), 64'd0);
        commit();
        check("c1_mem_valid", 64'(bus.mem_valid), 64'd1);
        check("c1_addr", 64'(bus.mem_req.addr), 64'h1000);
        check("c1_data", bus.mem_req.data, 64'h1122_3344);
        check("c1_strobe", 64'(bus.mem_req.strobe), 64'h0F);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("d1_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("d1_empty", 64'(bus.empty), 64'd1);

        // Commit on an empty buffer and commit in the push cycle are both ignored
        commit();
        bus.creq.valid = 1'b1;
        push(32'hA000, 8'h01, 64'h5A);
        bus.creq.valid = 1'b0;
        check("pc_mem_valid", 64'(bus.mem_valid), 64'd0);
        commit();
        check("pc2_mem_valid", 64'(bus.mem_valid), 64'd1);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("pc_empty", 64'(bus.empty), 64'd1);

        // Fill to DEPTH without commit
        for (int i = 0; i < 8; i++) begin
            push(32'h3000 + 32'(8 * i), 8'h01, 64'(i + 1));
        end
        check("full_ready", 64'(bus.wreq_ready), 64'd0);
        push(32'h4000, 8'hFF, 64'hDEAD);
        probe("ninth", 32'h4000, 8'h00, 64'h0);
        probe("last", 32'h3038, 8'h01, 64'h08);
        commit();
        check("full_mem_valid", 64'(bus.mem_valid), 64'd1);
        check("full_head_addr", 64'(bus.mem_req.addr), 64'h3000);
        // Pop with a push in the same cycle: the slot is not reusable yet
        bus.mem_ready  = 1'b1;
        bus.wreq.valid = 1'b1;
        bus.wreq.entry = '{addr: 32'h5000, msize: 2'd3, strobe: 8'hFF, data: 64'h55};
        #1;
        check("pop_ready_same", 64'(bus.wreq_ready), 64'd0);
        tick();
        bus.mem_ready  = 1'b0;
        bus.wreq.valid = 1'b0;
        check("pop_ready_next", 64'(bus.wreq_ready), 64'd1);
        check("pop_mem_valid", 64'(bus.mem_valid), 64'd0);
        probe("pop_push", 32'h5000, 8'h00, 64'h0);
        do_flush();
        check("fill_flush_empty", 64'(bus.empty), 64'd1);

        // Forward merge, youngest byte wins
        push(32'h2000, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA);
        push(32'h2004, 8'h0F, 64'hBBBB_BBBB);
        probe("fwd2", 32'h2000, 8'hFF, 64'hBBBB_BBBB_AAAA_AAAA);
        push(32'h2002, 8'h01, 64'hCC);
        probe("fwd3", 32'h2003, 8'hFF, 64'hBBBB_BBBB_AACC_AAAA);
        probe("fwd_other", 32'h2008, 8'h00, 64'h0);
        do_flush();
        check("fwd_flush_empty", 64'(bus.empty), 64'd1);

        // Flush keeps committed entries only
        for (int i = 0; i < 4; i++) begin
            push(32'h6000 + 32'(8 * i), 8'h0F, 64'(32'h100 + 32'(i)));
        end
        commit();
        commit();
        do_flush();
        check("fl_empty_before", 64'(bus.empty), 64'd0);
        probe("fl_gone", 32'h6010, 8'h00, 64'h0);
        probe("fl_kept", 32'h6008, 8'h0F, 64'h101);
        drains = 0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.mem_valid && drains < 4) begin
                drained[drains] = bus.mem_req.addr;
                drains++;
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        check("fl_drains", 64'(drains), 64'd2);
        check("fl_drain0", 64'(drained[0]), 64'h6000);
        check("fl_drain1", 64'(drained[1]), 64'h6008);
        check("fl_empty_after", 64'(bus.empty), 64'd1);

        // Same-cycle push + flush drops the push
        bus.flush = 1'b1;
        push(32'h7000, 8'hFF, 64'h77);
        bus.flush = 1'b0;
        check("pf_empty", 64'(bus.empty), 64'd1);
        probe("pf_absent", 32'h7000, 8'h00, 64'h0);

        // Backpressure: head entry held stable, then back-to-back drain
        push(32'h8000, 8'hFF, 64'h0123_4567_89AB_CDEF);
        push(32'h8008, 8'hFF, 64'hFEDC_BA98_7654_3210);
        commit();
        commit();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(bus.mem_valid), 64'd1);
            check("bp_addr", 64'(bus.mem_req.addr), 64'h8000);
            check("bp_data", bus.mem_req.data, 64'h0123_4567_89AB_CDEF);
            tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        check("bb_addr", 64'(bus.mem_req.addr), 64'h8008);
        check("bb_valid", 64'(bus.mem_valid), 64'd1);
        tick();
        bus.mem_ready = 1'b0;
        check("bb_empty", 64'(bus.empty), 64'd1);

        // Asynchronous reset while offering to memory
        push(32'h9000, 8'hFF, 64'h99);
        commit();
        push(32'h9008, 8'hFF, 64'h98);
        check("ar_mem_valid_pre", 64'(bus.mem_valid), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("ar_empty", 64'(bus.empty), 64'd1);
        check("ar_ready", 64'(bus.wreq_ready), 64'd1);
        probe("ar_probe", 32'h9008, 8'h00, 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("ar_empty_post", 64'(bus.empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
